// File: rtl/rr_priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_arbiter
// Purpose  : Registered N-way arbiter with selectable fixed-priority
//            (MSB highest) or round-robin search. A granted requester keeps
//            its grant while its request stays asserted. An optional hold
//            limit (MAX_HOLD) forces a release when others are waiting.
//            The grant is presented as a one-hot vector, as an encoded index
//            and with a valid flag.
// Ports    : clk          rising-edge clock
//            rst_n        asynchronous active-low reset
//            req          [N-1:0] level-sensitive request vector
//            mode         0 = fixed priority, 1 = round-robin
//            grant        [N-1:0] registered one-hot grant (zero when idle)
//            grant_idx    [IDXW-1:0] encoded grant index (zero when idle)
//            grant_valid  high while a grant is held
//            stat_preempt [15:0] forced-release count  (ARB_STATS_EN only)
//            stat_idle    [15:0] idle-cycle count      (ARB_STATS_EN only)
// Options  : define ARB_STATS_EN to add the saturating statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_arbiter #(
  parameter int N        = 16,
  parameter int IDXW     = $clog2(N),
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            mode,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_valid
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]     stat_preempt,
  output logic [15:0]     stat_idle
`endif
);

  localparam int              HCW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HCW-1:0]  HOLD_LAST = HCW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [IDXW-1:0] PTR_INIT  = IDXW'(N - 1);
  localparam logic [N-1:0]    ONE_N     = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            valid_q, valid_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [HCW-1:0]  hold_q, hold_d;
  logic            forced;

  // Arbitration datapath
  logic [N-1:0]    cand;
  logic [2*N-1:0]  dbl;
  logic [IDXW-1:0] rel_ptr;
  logic [IDXW-1:0] arb_ptr;
  logic            win_found;
  logic [IDXW-1:0] win_idx;
  logic [N-1:0]    win_oh;

  // The current holder is excluded from the candidates, so a single
  // arbiter serves both fresh arbitration (grant_q is zero in IDLE) and
  // release/handover (current holder never re-wins).
  // Round-robin uses the pointer the release would produce, so a
  // same-edge handover already sees the rotated search order.
  always_comb begin
    cand      = req & ~grant_q;
    rel_ptr   = (idx_q == '0) ? PTR_INIT : (idx_q - IDXW'(1));
    arb_ptr   = (state_q == S_GRANT) ? rel_ptr : ptr_q;
    dbl       = {cand, cand};
    win_found = 1'b0;
    win_idx   = '0;
    // Double-width masked priority select. Fixed mode keeps only the upper
    // copy (plain MSB-first). Round-robin keeps the window (ptr, N+ptr],
    // whose descending order is ptr..0 followed by N-1..ptr+1.
    // Ascending scan with last-hit-wins yields the highest kept bit.
    for (int j = 0; j < 2*N; j++) begin
      logic keep;
      if (mode) begin
        keep = (j > int'(arb_ptr)) && (j <= N + int'(arb_ptr));
      end else begin
        keep = (j >= N);
      end
      if (dbl[j] && keep) begin
        win_found = 1'b1;
        win_idx   = (j >= N) ? IDXW'(j - N) : IDXW'(j);
      end
    end
    win_oh = win_found ? (ONE_N << win_idx) : '0;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    forced  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_GRANT;
          grant_d = win_oh;
          idx_d   = win_idx;
          valid_d = 1'b1;
          hold_d  = '0;
        end
      end

      S_GRANT: begin
        if (!req[idx_q]) begin
          // Holder let go: hand over on the same edge, or go idle.
          ptr_d  = rel_ptr;
          hold_d = '0;
          if (win_found) begin
            grant_d = win_oh;
            idx_d   = win_idx;
            valid_d = 1'b1;
          end else begin
            state_d = S_IDLE;
            grant_d = '0;
            idx_d   = '0;
            valid_d = 1'b0;
          end
        end else if ((MAX_HOLD != 0) && (hold_q == HOLD_LAST) && win_found) begin
          // Hold limit reached with others waiting (win_found implies a
          // competing request since the holder is masked out).
          forced  = 1'b1;
          ptr_d   = rel_ptr;
          hold_d  = '0;
          grant_d = win_oh;
          idx_d   = win_idx;
        end else if ((MAX_HOLD != 0) && (hold_q != HOLD_LAST)) begin
          // Saturates at HOLD_LAST while uncontested.
          hold_d = hold_q + HCW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        idx_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= PTR_INIT;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;

`ifdef ARB_STATS_EN
  logic [15:0] preempt_q;
  logic [15:0] idle_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      preempt_q <= '0;
      idle_q    <= '0;
    end else begin
      if (forced && (preempt_q != 16'hFFFF)) begin
        preempt_q <= preempt_q + 16'd1;
      end
      if ((state_q == S_IDLE) && (idle_q != 16'hFFFF)) begin
        idle_q <= idle_q + 16'd1;
      end
    end
  end

  assign stat_preempt = preempt_q;
  assign stat_idle    = idle_q;
`else
  // Only the statistics counters consume this strobe.
  logic unused_forced;
  assign unused_forced = forced;
`endif

endmodule
`default_nettype wire

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
- Registered, parametrised successor to the team's 16-bit combinational left (MSB-first) arbiter.
- Arbitrates N request lines.
- Two selectable modes:
  - fixed priority: highest index wins, same result as the left arbiter;
  - round-robin: rotating search pointer.
- Adds grant locking while a request stays asserted, an optional hold-time limit, and a one-hot plus encoded grant with a valid flag.
- Sits in front of shared ALU/bus resources.

Parameters:
- N, 16, number of requesters (2..64)
- IDXW, $clog2(N), width of encoded grant index
- MAX_HOLD, 8, maximum consecutive grant cycles while other requests pend; 0 = unlimited

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N  request vector, level-sensitive
- mode  input  1  0 = fixed priority (MSB highest), 1 = round-robin
- grant  output  N  registered one-hot grant, all zero when idle
- grant_idx  output  IDXW  encoded index of grant, 0 when idle
- grant_valid  output  1  high when grant is nonzero

Behaviour:
- Reset (async, rst_n=0):
  - grant=0, grant_idx=0, grant_valid=0.
  - ptr=N-1, hold_cnt=0, state=IDLE.
  - Effective immediately, including mid-grant.
- Latency: req sampled at rising edge t; the resulting grant is visible after edge t (registered, 1 cycle). No combinational path from req to outputs.
- States:
  - IDLE:
    - If req==0, stay.
    - Else arbitrate, load grant, hold_cnt=0, go to GRANT.
  - GRANT (holding index k):
    - (a) If req[k]==0: release. Same edge, arbitrate among the remaining req (zero-bubble handover); if none, go to IDLE with outputs cleared.
    - (b) Else if MAX_HOLD!=0, hold_cnt==MAX_HOLD-1 and (req & ~onehot(k))!=0: forced release. Grant the next winner excluding k, hold_cnt=0.
    - (c) Otherwise keep k, hold_cnt += 1. Saturate at MAX_HOLD-1 when no other requests pend.
- Arbitration:
  - mode=0: winner = highest set index of candidate vector. ptr is ignored but still updated.
  - mode=1: scan descending starting at ptr, wrapping from 0 to N-1. The first set bit wins. Implemented as double-width masked priority select, not a loop over time.
- Pointer update: on every release of k (normal or forced), ptr = (k==0) ? N-1 : k-1. ptr is otherwise unchanged.
- mode changes mid-grant never break a lock. The new mode applies at the next arbitration.
- grant is always one-hot or zero. grant_idx is consistent with grant on the same cycle.
- X on req is never propagated as a grant. Idle outputs are driven zero, not left undefined.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined:
  - Adds output stat_preempt [15:0], a count of forced releases (case b). Saturates at 16'hFFFF; reset to 0.
  - Adds output stat_idle [15:0], a count of cycles in IDLE. Saturates; reset to 0.
- When undefined: neither port nor its counters exist, and all other behaviour is identical.

Test Plan:
- mode=0, req=16'h3765 held → after 1 edge grant=16'h2000, grant_idx=13, grant_valid=1. Then req=16'h0001 → grant=16'h0001, idx=0 on the next edge.
- mode=1, MAX_HOLD=4, req=16'h8001 constant from reset → grant 15 for 4 cycles, then 0 for 4 cycles, repeating. With ARB_STATS_EN, stat_preempt increments on each switch.
- mode=1, req=16'h0300 → grant idx 9 (ptr=15). Drop req[9] → same-edge handover to idx 8, ptr=8. Re-raise req[9] with req[8] dropped → idx 9 after 1 edge.
- Lock: mode=0, req=16'h0004 granted, then req=16'h0404 with MAX_HOLD=0 → grant stays 16'h0004 until req[2] drops. Then 16'h0400.
- Reset mid-operation: rst_n low during GRANT of idx 5 → grant=0, grant_valid=0 asynchronously, before the next clock edge. After release with req=16'h0021, mode=1 → idx 5 (ptr reset to 15).
- req=0 throughout → grant_valid=0, grant_idx=0 every cycle. With ARB_STATS_EN, stat_idle counts up and saturates at 16'hFFFF (force-load check).
